// File: rtl/ishift_p.sv
// rtl/ishift_p.sv - iterative multi-mode shifter/rotator, up to STEP bits per cycle
module ishift_p #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             go,
    input  logic [2:0]       fmt,
    input  logic [CW-1:0]    cnt,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);

    localparam int LW = $clog2(WIDTH);

    localparam logic [CW-1:0] L_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] L_STEP  = CW'(STEP);
    localparam logic [CW-1:0] L_ONE   = CW'(1);

    localparam logic [2:0] F_LSR = 3'd0;
    localparam logic [2:0] F_LSL = 3'd1;
    localparam logic [2:0] F_ASR = 3'd2;
    localparam logic [2:0] F_ASL = 3'd3;
    localparam logic [2:0] F_ROR = 3'd4;
    localparam logic [2:0] F_ROL = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_y, w_y_nx;
    logic [CW-1:0]    r_rem, w_rem_nx;
    logic [2:0]       r_fmt, w_fmt_nx;
    logic             r_carry, w_carry_nx;
    logic             r_ovf, w_ovf_nx;
    logic             r_done, w_done_nx;

    logic [CW-1:0]    w_eff;
    logic             w_big;
    logic [WIDTH-1:0] w_y_big, w_y_one;
    logic             w_c_big, w_c_one;
    logic             w_o_big, w_o_one;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v,
                                                 input logic [2:0] m, input int k);
        logic [WIDTH-1:0] r;
        case (m)
            F_LSR:        r = v >> k;
            F_LSL, F_ASL: r = v << k;
            F_ASR:        r = $signed(v) >>> k;
            F_ROR:        r = (v >> k) | (v << (WIDTH - k));
            F_ROL:        r = (v << k) | (v >> (WIDTH - k));
            default:      r = v;
        endcase
        return r;
    endfunction

    // Last bit to cross the boundary: y[k-1] going right, y[WIDTH-k] going left.
    function automatic logic f_carry(input logic [WIDTH-1:0] v,
                                     input logic [2:0] m, input int k);
        logic [WIDTH-1:0] t;
        if (m == F_LSR || m == F_ASR || m == F_ROR)
            t = v >> (k - 1);
        else
            t = v >> (WIDTH - k);
        return t[0];
    endfunction

    // The k bits shifted out plus the new sign bit are the top k+1 bits of {v,0}.
    function automatic logic f_ovf(input logic [WIDTH-1:0] v, input int k);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] top;
        logic [WIDTH:0] mask;
        ext  = {v, 1'b0};
        top  = ext >> (WIDTH - k);
        mask = {(WIDTH + 1){1'b1}} >> (WIDTH - k);
        return (top != '0) && (top != mask);
    endfunction

    always_comb begin
        w_eff = '0;
        case (fmt)
            F_LSR, F_LSL, F_ASR, F_ASL: w_eff = (cnt > L_WIDTH) ? L_WIDTH : cnt;
            F_ROR, F_ROL:               w_eff = {1'b0, cnt[LW-1:0]};
            default:                    w_eff = '0;
        endcase
    end

    assign w_big   = (r_rem >= L_STEP);
    assign w_y_big = f_shift(r_y, r_fmt, STEP);
    assign w_y_one = f_shift(r_y, r_fmt, 1);
    assign w_c_big = f_carry(r_y, r_fmt, STEP);
    assign w_c_one = f_carry(r_y, r_fmt, 1);
    assign w_o_big = f_ovf(r_y, STEP);
    assign w_o_one = f_ovf(r_y, 1);

    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_rem_nx   = r_rem;
        w_fmt_nx   = r_fmt;
        w_carry_nx = r_carry;
        w_ovf_nx   = r_ovf;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_nx = S_RUN;
                    w_y_nx     = a;
                    w_fmt_nx   = fmt;
                    w_rem_nx   = w_eff;
                    w_carry_nx = 1'b0;
                    w_ovf_nx   = 1'b0;
                end
            end
            S_RUN: begin
                if (r_rem == '0) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_y_nx     = w_big ? w_y_big : w_y_one;
                    w_rem_nx   = r_rem - (w_big ? L_STEP : L_ONE);
                    w_carry_nx = w_big ? w_c_big : w_c_one;
                    if (r_fmt == F_ASL && (w_big ? w_o_big : w_o_one))
                        w_ovf_nx = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_rem   <= '0;
            r_fmt   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_y     <= w_y_nx;
            r_rem   <= w_rem_nx;
            r_fmt   <= w_fmt_nx;
            r_carry <= w_carry_nx;
            r_ovf   <= w_ovf_nx;
            r_done  <= w_done_nx;
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = r_done;
    assign y     = r_y;
    assign carry = r_carry;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_ishift_p.sv
// tb/tb_ishift_p.sv - directed self-checking bench for ishift_p (WIDTH=32, STEP=4)
module tb_ishift_p;

    logic        clk = 1'b0;
    logic        arstn;
    logic        go;
    logic [2:0]  fmt;
    logic [5:0]  cnt;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        carry;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    ishift_p #(.WIDTH(32), .STEP(4)) dut (
        .clk   (clk),
        .arstn (arstn),
        .go    (go),
        .fmt   (fmt),
        .cnt   (cnt),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .carry (carry),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Issue one operation, scramble inputs after acceptance, count busy cycles
    // and confirm done is high exactly in the first idle cycle.
    task automatic run_op(input logic [2:0] f, input logic [5:0] c, input logic [31:0] v,
                          output int nbusy, output bit done_ok);
        bit d0, d1;
        nbusy = 0;
        @(negedge clk);
        fmt = f; cnt = c; a = v; go = 1'b1;
        @(negedge clk);
        go = 1'b0; fmt = ~f; cnt = ~c; a = ~v;
        while (busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
        d0 = done;
        @(negedge clk);
        d1 = done;
        done_ok = d0 && !d1;
    endtask

    task automatic test_reset();
        arstn = 1'b0; go = 1'b0; fmt = '0; cnt = '0; a = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (y !== 32'h0)    begin bad++; $display("FAIL reset_y got %h want 0", y); end
        total++; if ({carry, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {carry, ovf}); end
        arstn = 1'b1;
    endtask

    task automatic test_lsr();
        int nb; bit dk;
        run_op(3'd0, 6'd8, 32'd1000000, nb, dk);
        total++; if (y !== 32'd3906) begin bad++; $display("FAIL lsr8_y got %0d want 3906", y); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL lsr8_carry got %b want 0", carry); end
        total++; if (nb !== 3)       begin bad++; $display("FAIL lsr8_busy got %0d want 3", nb); end
        total++; if (dk !== 1'b1)    begin bad++; $display("FAIL lsr8_done got %b want 1", dk); end
        repeat (2) @(negedge clk);
        total++; if (y !== 32'd3906) begin bad++; $display("FAIL lsr8_hold got %0d want 3906", y); end
        run_op(3'd0, 6'd5, 32'h000000F0, nb, dk);
        total++; if (y !== 32'h7)    begin bad++; $display("FAIL lsr5_y got %h want 7", y); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL lsr5_carry got %b want 1", carry); end
        total++; if (nb !== 3)       begin bad++; $display("FAIL lsr5_busy got %0d want 3", nb); end
    endtask

    task automatic test_asr();
        int nb; bit dk;
        run_op(3'd2, 6'd3, 32'hFFF0BDC0, nb, dk);
        total++; if (y !== 32'hFFFE17B8) begin bad++; $display("FAIL asr3_y got %h want fffe17b8", y); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL asr3_carry got %b want 0", carry); end
        total++; if (nb !== 4)           begin bad++; $display("FAIL asr3_busy got %0d want 4", nb); end
        run_op(3'd0, 6'd3, 32'hFFF0BDC0, nb, dk);
        total++; if (y !== 32'h1FFE17B8) begin bad++; $display("FAIL lsr3neg_y got %h want 1ffe17b8", y); end
    endtask

    task automatic test_asl();
        int nb; bit dk;
        run_op(3'd3, 6'd4, 32'hFFFFFC18, nb, dk);
        total++; if (y !== 32'hFFFFC180) begin bad++; $display("FAIL asl4_y got %h want ffffc180", y); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL asl4_ovf got %b want 0", ovf); end
        total++; if (carry !== 1'b1)     begin bad++; $display("FAIL asl4_carry got %b want 1", carry); end
        total++; if (nb !== 2)           begin bad++; $display("FAIL asl4_busy got %0d want 2", nb); end
        run_op(3'd3, 6'd1, 32'h40000000, nb, dk);
        total++; if (y !== 32'h80000000) begin bad++; $display("FAIL asl1_y got %h want 80000000", y); end
        total++; if (ovf !== 1'b1)       begin bad++; $display("FAIL asl1_ovf got %b want 1", ovf); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL asl1_carry got %b want 0", carry); end
        repeat (2) @(negedge clk);
        total++; if (ovf !== 1'b1)       begin bad++; $display("FAIL asl1_ovf_hold got %b want 1", ovf); end
        run_op(3'd3, 6'd4, 32'h00000001, nb, dk);
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL asl_ovf_clear got %b want 0", ovf); end
        total++; if (y !== 32'h10)       begin bad++; $display("FAIL asl_small_y got %h want 10", y); end
    endtask

    task automatic test_rotate();
        int nb; bit dk;
        run_op(3'd4, 6'd4, 32'h80000405, nb, dk);
        total++; if (y !== 32'h58000040) begin bad++; $display("FAIL ror4_y got %h want 58000040", y); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL ror4_carry got %b want 0", carry); end
        run_op(3'd5, 6'd36, 32'h50000678, nb, dk);
        total++; if (y !== 32'h00006785) begin bad++; $display("FAIL rol36_y got %h want 00006785", y); end
        total++; if (carry !== 1'b1)     begin bad++; $display("FAIL rol36_carry got %b want 1", carry); end
        total++; if (nb !== 2)           begin bad++; $display("FAIL rol36_busy got %0d want 2", nb); end
        run_op(3'd4, 6'd32, 32'h12345678, nb, dk);
        total++; if (y !== 32'h12345678) begin bad++; $display("FAIL ror32_y got %h want 12345678", y); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL ror32_carry got %b want 0", carry); end
        total++; if (nb !== 1)           begin bad++; $display("FAIL ror32_busy got %0d want 1", nb); end
    endtask

    task automatic test_clamp_pass();
        int nb; bit dk;
        run_op(3'd1, 6'd40, 32'h00000001, nb, dk);
        total++; if (y !== 32'h0)        begin bad++; $display("FAIL lsl40_y got %h want 0", y); end
        total++; if (carry !== 1'b1)     begin bad++; $display("FAIL lsl40_carry got %b want 1", carry); end
        total++; if (nb !== 9)           begin bad++; $display("FAIL lsl40_busy got %0d want 9", nb); end
        run_op(3'd6, 6'd9, 32'h12345678, nb, dk);
        total++; if (y !== 32'h12345678) begin bad++; $display("FAIL pass6_y got %h want 12345678", y); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL pass6_carry got %b want 0", carry); end
        total++; if (nb !== 1)           begin bad++; $display("FAIL pass6_busy got %0d want 1", nb); end
        total++; if (dk !== 1'b1)        begin bad++; $display("FAIL pass6_done got %b want 1", dk); end
        run_op(3'd7, 6'd3, 32'hCAFEF00D, nb, dk);
        total++; if (y !== 32'hCAFEF00D) begin bad++; $display("FAIL pass7_y got %h want cafef00d", y); end
    endtask

    task automatic test_mid_go();
        int nb;
        @(negedge clk);
        fmt = 3'd0; cnt = 6'd8; a = 32'h12345678; go = 1'b1;
        @(negedge clk);
        fmt = 3'd1; cnt = 6'd3; a = 32'hFFFFFFFF;
        @(negedge clk);
        go = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin nb++; @(negedge clk); end
        total++; if (y !== 32'h00123456) begin bad++; $display("FAIL midgo_y got %h want 00123456", y); end
        total++; if (carry !== 1'b0)     begin bad++; $display("FAIL midgo_carry got %b want 0", carry); end
        @(negedge clk);
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midgo_idle got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int nb;
        @(negedge clk);
        fmt = 3'd0; cnt = 6'd4; a = 32'h00000100; go = 1'b1;
        @(negedge clk);
        fmt = 3'd1; cnt = 6'd4; a = 32'h00000003;
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL b2b_gap got %b want 01", {busy, done}); end
        total++; if (y !== 32'h10)           begin bad++; $display("FAIL b2b_y1 got %h want 10", y); end
        @(negedge clk);
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_restart got %b want 10", {busy, done}); end
        go = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin nb++; @(negedge clk); end
        total++; if (y !== 32'h30)           begin bad++; $display("FAIL b2b_y2 got %h want 30", y); end
        total++; if (nb !== 2)               begin bad++; $display("FAIL b2b_busy2 got %0d want 2", nb); end
    endtask

    task automatic test_reset_mid();
        int nb; bit dk;
        @(negedge clk);
        fmt = 3'd3; cnt = 6'd20; a = 32'h40000001; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        total++; if ({busy, done, carry, ovf} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got %b want 0000", {busy, done, carry, ovf}); end
        total++; if (y !== 32'h0) begin bad++; $display("FAIL rstmid_y got %h want 0", y); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_stay got %b want 0", busy); end
        run_op(3'd0, 6'd8, 32'd1000000, nb, dk);
        total++; if (y !== 32'd3906) begin bad++; $display("FAIL rstmid_after_y got %0d want 3906", y); end
        total++; if (nb !== 3)       begin bad++; $display("FAIL rstmid_after_busy got %0d want 3", nb); end
    endtask

    initial begin
        test_reset();
        test_lsr();
        test_asr();
        test_asl();
        test_rotate();
        test_clamp_pass();
        test_mid_go();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
